wb_arbiter: RTL and testbench

- Writeback-side producer for the core's 32x32 register file: drives its single write port (wen/waddr/wdata).
- Merges two result sources onto that port:
  - single-cycle ALU/execute results, which have priority;
  - out-of-order, long-latency LSU/multiplier results, held in a small FIFO.
- Suppresses x0 writes and bounds LSU starvation so that no source can monopolise the port.

---
 rtl/wb_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with buffered LSU results
// onto the register file's single write port, with x0 suppression and starvation bounding.
module wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [4:0]               lsu_rd,
  input  logic [31:0]              lsu_data,
  output logic                     wen,
  output logic [4:0]               waddr,
  output logic [31:0]              wdata,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    rdMem_q   [DEPTH];
  logic [31:0]   dataMem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          wen_q, wen_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic aluXfer, lsuXfer, fifoEmpty;
  logic aluWin, pop, bypass, push;

  // Readies depend only on registered state, so a same-cycle pop never frees a slot for a push.
  assign lsu_ready = (count_q != CW'(DEPTH));
  assign alu_ready = (starve_q != SW'(STARVE_MAX));
  assign aluXfer   = alu_valid && alu_ready;
  assign lsuXfer   = lsu_valid && lsu_ready;
  assign fifoEmpty = (count_q == '0);

  assign aluWin = aluXfer && (alu_rd != 5'd0);
  assign pop    = !aluWin && !fifoEmpty;
  assign bypass = !aluWin && fifoEmpty && lsuXfer && (lsu_rd != 5'd0);
  assign push   = lsuXfer && (lsu_rd != 5'd0) && !bypass;

  always_comb begin
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    starve_d = starve_q;

    if (aluWin) begin
      wen_d   = 1'b1;
      waddr_d = alu_rd;
      wdata_d = alu_data;
    end else if (pop) begin
      wen_d   = 1'b1;
      waddr_d = rdMem_q[head_q];
      wdata_d = dataMem_q[head_q];
    end else if (bypass) begin
      wen_d   = 1'b1;
      waddr_d = lsu_rd;
      wdata_d = lsu_data;
    end

    if (pop) begin
      head_d = head_q + AW'(1);
    end
    if (push) begin
      tail_d = tail_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    // The counter only measures losses while something is actually waiting.
    if (fifoEmpty || pop) begin
      starve_d = '0;
    end else if (aluWin && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rdMem_q[tail_q]   <= lsu_rd;
      dataMem_q[tail_q] <= lsu_data;
    end
  end

  assign wen        = wen_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts every
// register file write, and a monitor compares each observed write against it.
module tb_wb_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, waddr;
  logic [31:0] alu_data, lsu_data, wdata;
  logic        wen;
  logic [$clog2(DEPTH):0] fifo_count;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t modelQ[$];
  wr_t expQ[$];
  int  starve;
  int  checks   = 0;
  int  failures = 0;
  logic aT, lT;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wen(wen), .waddr(waddr), .wdata(wdata), .fifo_count(fifo_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    modelQ.delete();
    expQ.delete();
    starve = 0;
  endtask

  // One cycle: check readies/count against the model, drive inputs, then advance the model.
  task automatic applyStimulus(input logic aV, input logic [4:0] aRd, input logic [31:0] aD,
                               input logic lV, input logic [4:0] lRd, input logic [31:0] lD,
                               output logic aXfer, output logic lXfer);
    logic expAR, expLR;
    bit   wasEmpty, bypassed;
    wr_t  w;
    @(negedge clk);
    expAR = (starve != STARVE_MAX);
    expLR = (modelQ.size() < DEPTH);
    checkOutput("alu_ready", 32'(alu_ready), 32'(expAR));
    checkOutput("lsu_ready", 32'(lsu_ready), 32'(expLR));
    checkOutput("fifo_count", 32'(fifo_count), 32'(modelQ.size()));
    alu_valid = aV; alu_rd = aRd; alu_data = aD;
    lsu_valid = lV; lsu_rd = lRd; lsu_data = lD;
    aXfer    = aV && expAR;
    lXfer    = lV && expLR;
    wasEmpty = (modelQ.size() == 0);
    bypassed = 0;
    if (aXfer && aRd != 5'd0) begin
      w.rd = aRd; w.data = aD;
      expQ.push_back(w);
      if (!wasEmpty && starve < STARVE_MAX) starve++;
    end else if (!wasEmpty) begin
      expQ.push_back(modelQ.pop_front());
      starve = 0;
    end else if (lXfer && lRd != 5'd0) begin
      w.rd = lRd; w.data = lD;
      expQ.push_back(w);
      bypassed = 1;
    end
    if (wasEmpty) starve = 0;
    if (lXfer && lRd != 5'd0 && !bypassed) begin
      w.rd = lRd; w.data = lD;
      modelQ.push_back(w);
    end
  endtask

  task automatic idleCycles(input int n);
    logic a, l;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a, l);
  endtask

  // Monitor: every write the DUT presents must match the oldest predicted write.
  initial begin
    wr_t w;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1 && wen === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write actual waddr=%0d wdata=%0h expected no write at %0t", waddr, wdata, $time);
        end else begin
          w = expQ.pop_front();
          checkOutput("waddr", 32'(waddr), 32'(w.rd));
          checkOutput("wdata", wdata, w.data);
        end
      end
    end
  end

  initial begin
    int stallCycle, maxCount, li;
    logic [4:0] lsuRds [3];
    logic aPend, lPend;
    logic [4:0]  aRdP, lRdP;
    logic [31:0] aDP, lDP;

    rst = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    resetModel();
    #12;
    checkOutput("reset_wen", 32'(wen), 32'd0);
    checkOutput("reset_waddr", 32'(waddr), 32'd0);
    checkOutput("reset_wdata", wdata, 32'd0);
    checkOutput("reset_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] ALU-only");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, aT, lT);
    @(posedge clk); #1;
    checkOutput("alu_wen", 32'(wen), 32'd1);
    checkOutput("alu_waddr", 32'(waddr), 32'd5);
    checkOutput("alu_wdata", wdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, aT, lT);
    @(posedge clk); #1;
    checkOutput("alu_x0_wen", 32'(wen), 32'd0);
    checkOutput("alu_x0_ready", 32'(alu_ready), 32'd1);

    $display("[TB] LSU bypass");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA5A5A5A5, aT, lT);
    @(posedge clk); #1;
    checkOutput("bypass_wen", 32'(wen), 32'd1);
    checkOutput("bypass_waddr", 32'(waddr), 32'd7);
    checkOutput("bypass_count", 32'(fifo_count), 32'd0);
    idleCycles(2);

    $display("[TB] contention and starvation");
    lsuRds[0] = 5'd1; lsuRds[1] = 5'd2; lsuRds[2] = 5'd3;
    stallCycle = -1; maxCount = 0; li = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, 5'(10 + c), 32'h1000 + 32'(c), li < 3, (li < 3) ? lsuRds[li] : 5'd0,
                    32'h2000 + 32'(li), aT, lT);
      if (alu_ready == 1'b0 && stallCycle < 0) stallCycle = c;
      if (int'(fifo_count) > maxCount) maxCount = int'(fifo_count);
      if (lT) li++;
    end
    checkOutput("first_stall_cycle", 32'(stallCycle), 32'd5);
    checkOutput("max_fifo_count", 32'(maxCount), 32'd2);
    idleCycles(4);

    $display("[TB] simultaneous push and pop");
    applyStimulus(1'b1, 5'd11, 32'hB0, 1'b1, 5'd8, 32'hC8, aT, lT);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hC9, aT, lT);
    @(posedge clk); #1;
    checkOutput("pushpop_waddr", 32'(waddr), 32'd8);
    checkOutput("pushpop_count", 32'(fifo_count), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, aT, lT);
    @(posedge clk); #1;
    checkOutput("pushpop_next_waddr", 32'(waddr), 32'd9);
    idleCycles(2);

    $display("[TB] x0 LSU");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, aT, lT);
    @(posedge clk); #1;
    checkOutput("lsu_x0_wen", 32'(wen), 32'd0);
    checkOutput("lsu_x0_count", 32'(fifo_count), 32'd0);
    checkOutput("lsu_x0_ready", 32'(lsu_ready), 32'd1);

    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 5'd12, 32'hE0, 1'b1, 5'd4, 32'hF4, aT, lT);
    applyStimulus(1'b1, 5'd13, 32'hE1, 1'b1, 5'd5, 32'hF5, aT, lT);
    @(negedge clk);
    checkOutput("preburst_count", 32'(fifo_count), 32'd2);
    #2;
    rst = 1'b0;
    alu_valid = 0; lsu_valid = 0;
    resetModel();
    #1;
    checkOutput("midreset_wen", 32'(wen), 32'd0);
    checkOutput("midreset_count", 32'(fifo_count), 32'd0);
    checkOutput("midreset_alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("midreset_lsu_ready", 32'(lsu_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    idleCycles(3);
    @(posedge clk); #1;
    checkOutput("post_reset_wen", 32'(wen), 32'd0);

    $display("[TB] random traffic");
    aPend = 0; lPend = 0; aRdP = 0; lRdP = 0; aDP = 0; lDP = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!aPend && ($urandom % 4 != 0)) begin
        aPend = 1;
        aRdP  = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        aDP   = $urandom;
      end
      if (!lPend && ($urandom % 2 == 0)) begin
        lPend = 1;
        lRdP  = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        lDP   = $urandom;
      end
      applyStimulus(aPend, aRdP, aDP, lPend, lRdP, lDP, aT, lT);
      if (aT) aPend = 0;
      if (lT) lPend = 0;
    end

    for (int i = 0; i < 20 && modelQ.size() != 0; i++) idleCycles(1);
    idleCycles(2);
    @(posedge clk); #1;
    checkOutput("drain_model_fifo", 32'(modelQ.size()), 32'd0);
    checkOutput("pending_expected_writes", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
